// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the 8-source interrupt priority controller.
package irq_pkg;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_ctrl8_if.sv
// Grant handshake between the controller (master) and the interrupt consumer (slave).
interface irq_prio_ctrl8_if;
    import irq_pkg::*;

    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            eoi;
    logic            busy;

    modport master (
        output irq_valid,
        output irq_id,
        output busy,
        input  irq_ack,
        input  eoi
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        input  busy,
        output irq_ack,
        output eoi
    );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; bit 7 has the highest priority.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] elig,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        id  = '0;
        any = |elig;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (elig[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl8.sv
// Eight-source interrupt controller: falling-edge capture into pend, mask/enable
// qualification, and a request/ack/eoi grant sequence to a single consumer.
module irq_prio_ctrl8
    import irq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_n,
    input  logic [NUM_IRQ-1:0]  mask,
    input  logic                en_n,
    irq_prio_ctrl8_if.master    bus,
    output logic [NUM_IRQ-1:0]  pend,
    output logic                ovf,
    input  logic                ovf_clr
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] fall;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] elig;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    id_q;
    logic               any;
    logic               latch;
    state_t             state;
    state_t             state_nxt;

    assign fall       = irq_q & ~irq_n;
    assign elig       = pend & ~mask;
    assign bus.irq_id = id_q;

    prio_enc8 u_prio_enc8 (
        .elig (elig),
        .id   (win_id),
        .any  (any)
    );

    // Edge capture, pending register and sticky overflow; set wins over clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= '1;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            irq_q <= irq_n;
            pend  <= fall | (pend & ~clr);
            if (|(fall & pend & ~clr)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Next-state logic; ack takes priority over withdrawal in REQ.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (!en_n && any) begin
                    state_nxt = REQ;
                    latch     = 1'b1;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    state_nxt = SVC;
                    clr[id_q] = 1'b1;
                end else if (en_n || mask[id_q]) begin
                    state_nxt = IDLE;
                end
            end
            SVC: begin
                if (bus.eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            id_q          <= '0;
            bus.irq_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.irq_valid <= (state_nxt == REQ);
            bus.busy      <= (state_nxt == SVC);
            if (latch) begin
                id_q <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_prio_ctrl8.sv
// Scenario bench for irq_prio_ctrl8: expected grant IDs queued at stimulus, popped at grant.
module tb_irq_prio_ctrl8;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_n;
    logic [7:0] mask;
    logic       en_n;
    logic [7:0] pend;
    logic       ovf;
    logic       ovf_clr;

    irq_prio_ctrl8_if bus ();

    irq_prio_ctrl8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_n   (irq_n),
        .mask    (mask),
        .en_n    (en_n),
        .bus     (bus),
        .pend    (pend),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_id;
    bit          ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hF;
    endtask

    // Bounded wait for irq_valid; ok reports whether it appeared.
    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.irq_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_n = 8'hFF; mask = 8'h00; en_n = 1'b0;
        ovf_clr = 1'b0; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        step(); step();
        checks++;
        if (bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0 || bus.busy !== 1'b0 ||
            pend !== 8'h00 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: valid=%b id=%0d busy=%b pend=%h ovf=%b, want 0 0 0 00 0",
                     bus.irq_valid, bus.irq_id, bus.busy, pend, ovf);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        irq_n = ~8'h08; exp_q.push_back(4'd3);
        step();
        checks++;
        if (pend !== 8'h08 || bus.irq_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_e0: pend=%h valid=%b, want 08 0", pend, bus.irq_valid);
        end
        irq_n = 8'hFF;
        step();
        pop_exp();
        checks++;
        if (bus.irq_valid !== 1'b1 || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL basic_e1: valid=%b id=%0d, want 1 %0d", bus.irq_valid, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.irq_valid !== 1'b0 || pend !== 8'h00) begin
            failures++;
            $display("FAIL basic_ack: busy=%b valid=%b pend=%h, want 1 0 00", bus.busy, bus.irq_valid, pend);
        end
        bus.eoi = 1'b1;
        step();
        bus.eoi = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.irq_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_eoi: busy=%b valid=%b, want 0 0", bus.busy, bus.irq_valid);
        end
    endtask

    task automatic test_simultaneous();
        irq_n = ~8'h64;
        exp_q.push_back(4'd6); exp_q.push_back(4'd5); exp_q.push_back(4'd2);
        step();
        irq_n = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            pop_exp();
            checks++;
            if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
                failures++;
                $display("FAIL simul_grant%0d: found=%b id=%0d, want 1 %0d", k, ok, bus.irq_id, exp_id);
            end
            bus.irq_ack = 1'b1;
            step();
            bus.irq_ack = 1'b0;
            bus.eoi = 1'b1;
            step();
            bus.eoi = 1'b0;
            checks++;
            if (bus.irq_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL simul_idle%0d: valid=%b busy=%b, want 0 0", k, bus.irq_valid, bus.busy);
            end
        end
    endtask

    task automatic test_no_preempt();
        irq_n = ~8'h10; exp_q.push_back(4'd4);
        step();
        irq_n = 8'hFF;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL preempt_first: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        irq_n = ~8'h80; exp_q.push_back(4'd7);
        step();
        irq_n = 8'hFF;
        step();
        checks++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4 || pend !== 8'h90) begin
            failures++;
            $display("FAIL preempt_hold: valid=%b id=%0d pend=%h, want 1 4 90", bus.irq_valid, bus.irq_id, pend);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL preempt_next: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
    endtask

    task automatic test_mask_withdraw();
        irq_n = ~8'h02; exp_q.push_back(4'd1);
        step();
        irq_n = 8'hFF;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL mask_grant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        mask = 8'h02; exp_q.push_back(4'd1);
        step(); step();
        checks++;
        if (bus.irq_valid !== 1'b0 || pend !== 8'h02) begin
            failures++;
            $display("FAIL mask_withdraw: valid=%b pend=%h, want 0 02", bus.irq_valid, pend);
        end
        mask = 8'h00;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL mask_regrant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        en_n = 1'b1; exp_q.push_back(4'd1);
        step(); step(); step();
        checks++;
        if (bus.irq_valid !== 1'b0 || pend !== 8'h02) begin
            failures++;
            $display("FAIL disable_nogrant: valid=%b pend=%h, want 0 02", bus.irq_valid, pend);
        end
        en_n = 1'b0;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL enable_regrant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
    endtask

    task automatic test_ovf();
        en_n = 1'b1;
        irq_n = ~8'h01; exp_q.push_back(4'd0);
        step(); irq_n = 8'hFF; step();
        checks++;
        if (ovf !== 1'b0 || pend !== 8'h01) begin
            failures++;
            $display("FAIL ovf_first: ovf=%b pend=%h, want 0 01", ovf, pend);
        end
        irq_n = ~8'h01;
        step(); irq_n = 8'hFF;
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b, want 1", ovf);
        end
        step();
        irq_n = ~8'h01; ovf_clr = 1'b1;
        step(); irq_n = 8'hFF; ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins: ovf=%b, want 1", ovf);
        end
        ovf_clr = 1'b1;
        step(); ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
        end
        en_n = 1'b0;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL ovf_grant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        irq_n = ~8'h01; bus.irq_ack = 1'b1; exp_q.push_back(4'd0);
        step();
        irq_n = 8'hFF; bus.irq_ack = 1'b0;
        checks++;
        if (pend !== 8'h01 || bus.busy !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ack_edge: pend=%h busy=%b ovf=%b, want 01 1 0", pend, bus.busy, ovf);
        end
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL ack_edge_regrant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
    endtask

    task automatic test_reset_mid();
        irq_n = ~8'h20; exp_q.push_back(4'd5);
        step(); irq_n = 8'hFF;
        wait_valid(ok);
        pop_exp();
        checks++;
        if (!ok || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL rmid_grant: found=%b id=%0d, want 1 %0d", ok, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        irq_n = ~8'h08; step(); irq_n = 8'hFF; step();
        irq_n = ~8'h08; step(); irq_n = 8'hFF;
        checks++;
        if (bus.busy !== 1'b1 || pend !== 8'h08 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL rmid_svc: busy=%b pend=%h ovf=%b, want 1 08 1", bus.busy, pend, ovf);
        end
        rst_n = 1'b0; irq_n = ~8'h04;
        step();
        checks++;
        if (bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0 || bus.busy !== 1'b0 ||
            pend !== 8'h00 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rmid_reset: valid=%b id=%0d busy=%b pend=%h ovf=%b, want 0 0 0 00 0",
                     bus.irq_valid, bus.irq_id, bus.busy, pend, ovf);
        end
        rst_n = 1'b1; exp_q.push_back(4'd2);
        step();
        checks++;
        if (pend !== 8'h04 || bus.irq_valid !== 1'b0) begin
            failures++;
            $display("FAIL held_low_e0: pend=%h valid=%b, want 04 0", pend, bus.irq_valid);
        end
        step();
        pop_exp();
        checks++;
        if (bus.irq_valid !== 1'b1 || {1'b0, bus.irq_id} !== exp_id) begin
            failures++;
            $display("FAIL held_low_grant: valid=%b id=%0d, want 1 %0d", bus.irq_valid, bus.irq_id, exp_id);
        end
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
        step(); step(); step();
        checks++;
        if (bus.irq_valid !== 1'b0 || pend !== 8'h00) begin
            failures++;
            $display("FAIL held_low_once: valid=%b pend=%h, want 0 00", bus.irq_valid, pend);
        end
        irq_n = 8'hFF;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_no_preempt();
        test_mask_withdraw();
        test_ovf();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || pend !== 8'h00) begin
            failures++;
            $display("FAIL drain: queued=%0d pend=%h, want 0 00", exp_q.size(), pend);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl8.md
# irq_prio_ctrl8

Eight-source interrupt priority controller that sequences the 8-to-3 priority-encoding function into a request/acknowledge/end-of-interrupt protocol. It captures falling edges on active-low request lines into a pending register, applies a mask and an active-low global enable, and presents one winning source ID to a single consumer. It holds that ID until the consumer acknowledges and later signals end of service. It sits between raw peripheral request lines and the CPU/interrupt-service logic.

## Interface
- No parameters. Fixed at 8 sources; ID width is 3.
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- irq_n  in  8  request lines, active-low, synchronous to clk; falling edge = new request
- mask  in  8  1 = source ineligible for grant; its pending bit is retained
- en_n  in  1  global grant enable, active-low
- irq_valid  out  1  a granted ID is presented
- irq_id  out  3  granted source, true binary; 7 = highest priority
- irq_ack  in  1  consumer accepts the grant
- eoi  in  1  consumer finished servicing
- busy  out  1  in service (between ack and eoi)
- pend  out  8  pending register, for visibility
- ovf  out  1  sticky: an edge arrived on a line already pending
- ovf_clr  in  1  clears ovf

## Operation
- Edge detect:
  - irq_q <= irq_n every cycle.
  - fall[i] = irq_q[i] & ~irq_n[i].
  - irq_q resets to 8'hFF, so a line held low at reset release counts as one edge.
- Pending update per bit, same edge:
  - pend[i] <= fall[i] | (pend[i] & ~clr[i]).
  - clr[i] is 1 only for the acknowledged ID on an accepted ack.
  - Set wins over clear.
- ovf update:
  - ovf set when fall[i] & pend[i] & ~clr[i] for any i.
  - ovf_clr clears it; set wins over clear in the same cycle.
- Eligibility: elig = pend & ~mask. Winner is the highest set index of elig; any = |elig.
- FSM states:
  - IDLE
    - If en_n=0 and any: latch irq_id = winner and go to REQ.
    - Otherwise stay.
  - REQ: irq_valid=1; irq_id frozen.
    - irq_ack=1: clear pend[irq_id] and go to SVC.
    - Else if en_n=1 or mask[irq_id]=1: withdraw to IDLE; pend kept.
    - Ack has priority over withdrawal in the same cycle.
  - SVC: busy=1; irq_id holds its last value.
    - eoi=1: go to IDLE.
    - en_n and mask are ignored.
- Ignored inputs: irq_ack outside REQ; eoi outside SVC.
- No preemption: a higher-priority edge during REQ or SVC only sets pend.
- Reset values: state IDLE, pend 0, irq_q FF, irq_valid 0, irq_id 0, busy 0, ovf 0.

## Timing
- Edge E0 is the first edge that samples irq_n[i]=0 with irq_q[i]=1.
  - pend[i]=1 after E0.
  - irq_valid=1 after E1 (latency 2 edges), if IDLE, enabled, unmasked and winning.
- Ack accepted at edge Ea:
  - After Ea: irq_valid=0, busy=1, pend bit cleared.
- eoi accepted at edge Ee:
  - After Ee: busy=0.
  - Earliest next irq_valid is after Ee+1; one idle cycle minimum between grants.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset mid-operation: every output and the state return to reset values on the next edge, regardless of state.

## Structure
- Package irq_pkg:
  - NUM_IRQ=8, ID_W=3.
  - State enum {IDLE, REQ, SVC}.
- Sub-module prio_enc8: combinational. Input elig[7:0]; outputs id[2:0] and any. Active-high, bit 7 highest priority. Instantiated once.
- Top contains edge detect, pend/ovf registers and the FSM.

## Test plan
- Reset with irq_n=FF, then irq_n[3] pulsed low 1 cycle, mask=0, en_n=0:
  - pend=08 after E0.
  - irq_valid=1, irq_id=3 after E1.
  - ack gives busy=1 and pend=00; eoi gives busy=0.
- Simultaneous edges on lines 2, 5, 6:
  - Grants in order 6, 5, 2, each after ack/eoi.
  - Each grant waits at least one idle cycle after eoi.
- Grant of 4 in REQ, then edge on 7 before ack:
  - irq_id stays 4.
  - After eoi, next grant is 7.
- Line 1 pending:
  - mask[1]=1 while in REQ: withdraws to IDLE, pend=02 kept.
  - Unmask: regrant of 1.
  - en_n=1 while pending: no grant.
- Line 0 pending, second edge on line 0:
  - ovf=1.
  - ovf_clr in the same cycle as another new edge leaves ovf=1.
  - Edge in the ack cycle of line 0: pend[0] stays 1.
- rst_n=0 asserted while in SVC:
  - All outputs return to reset values after the next edge.
  - A line held low at release produces one grant.
